// File: rtl/synaptic_weight_accumulator_pkg.sv
// Shared widths and state encoding for the synaptic weight accumulator.
package synaptic_weight_accumulator_pkg;

   localparam int SWA_INTEGER_WIDTH   = 16;
   localparam int SWA_DATA_WIDTH_FRAC = 32;
   localparam int SWA_DATA_WIDTH      = SWA_INTEGER_WIDTH + SWA_DATA_WIDTH_FRAC;
   localparam int SWA_AXON_ID_WIDTH   = 10;
   localparam int SWA_NEURON_ID_WIDTH = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } swa_state_e;

endpackage

// File: rtl/saturating_adder.sv
// Signed adder that clamps to the representable range instead of wrapping.
module saturating_adder #(
   parameter int DATA_WIDTH = 48
) (
   input  logic signed [DATA_WIDTH-1:0] a,
   input  logic signed [DATA_WIDTH-1:0] b,
   output logic signed [DATA_WIDTH-1:0] sum
);

   localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic signed [DATA_WIDTH-1:0] raw;
   logic                         pos_ovf;
   logic                         neg_ovf;

   assign raw = a + b;

   // Overflow only possible when both operands share a sign the result lacks
   always_comb begin
      pos_ovf = ~a[DATA_WIDTH-1] & ~b[DATA_WIDTH-1] &  raw[DATA_WIDTH-1];
      neg_ovf =  a[DATA_WIDTH-1] &  b[DATA_WIDTH-1] & ~raw[DATA_WIDTH-1];
      if (pos_ovf)
         sum = SAT_MAX;
      else if (neg_ovf)
         sum = SAT_MIN;
      else
         sum = raw;
   end

endmodule

// File: rtl/synaptic_weight_accumulator.sv
// Accumulates presynaptic weights for one neuron into separate excitatory
// and inhibitory-magnitude sums, reading one weight per accepted spike.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_IDLE  | waiting for Start; sums hold their last final values
//  ST_ACCUM | accepting spikes, one weight read per accepted spike
//  ST_DRAIN | last read data in flight, folded into sums at end of cycle
//  ST_DONE  | sums final, Done pulsed for this single cycle
module synaptic_weight_accumulator
   import synaptic_weight_accumulator_pkg::*;
#(
   parameter int INTEGER_WIDTH   = SWA_INTEGER_WIDTH,
   parameter int DATA_WIDTH_FRAC = SWA_DATA_WIDTH_FRAC,
   parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
   parameter int AXON_ID_WIDTH   = SWA_AXON_ID_WIDTH,
   parameter int NEURON_ID_WIDTH = SWA_NEURON_ID_WIDTH
) (
   input  logic                                     Clock,
   input  logic                                     Reset,
   input  logic                                     Start,
   input  logic [NEURON_ID_WIDTH-1:0]               NeuronID,
   input  logic [AXON_ID_WIDTH:0]                   SpikeCount,
   input  logic                                     SpikeValid,
   input  logic [AXON_ID_WIDTH-1:0]                 SpikeAxonID,
   output logic                                     SpikeReady,
   output logic                                     WeightRdEn,
   output logic [AXON_ID_WIDTH+NEURON_ID_WIDTH-1:0] WeightAddr,
   input  logic signed [DATA_WIDTH-1:0]             WeightData,
   output logic signed [DATA_WIDTH-1:0]             ExWeightSum,
   output logic signed [DATA_WIDTH-1:0]             InWeightSum,
   output logic                                     Busy,
   output logic                                     Done
);

   localparam int CNT_W = AXON_ID_WIDTH + 1;
   localparam logic signed [DATA_WIDTH-1:0] SUM_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [DATA_WIDTH-1:0] SUM_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   swa_state_e                   state;
   logic [CNT_W-1:0]             spike_cnt;
   logic [NEURON_ID_WIDTH-1:0]   nid_q;
   logic                         rd_pending;
   logic                         done_q;
   logic                         busy_q;
   logic                         accept;
   logic                         start_ok;
   logic signed [DATA_WIDTH-1:0] ex_sum;
   logic signed [DATA_WIDTH-1:0] in_sum;
   logic signed [DATA_WIDTH-1:0] ex_add;
   logic signed [DATA_WIDTH-1:0] in_add;
   logic signed [DATA_WIDTH-1:0] ex_next;
   logic signed [DATA_WIDTH-1:0] in_next;

   assign SpikeReady  = (state == ST_ACCUM) && (spike_cnt != '0);
   assign accept      = SpikeValid & SpikeReady;
   assign start_ok    = Start && (state == ST_IDLE);
   assign WeightRdEn  = accept;
   assign WeightAddr  = accept ? {SpikeAxonID, nid_q} : '0;
   assign ExWeightSum = ex_sum;
   assign InWeightSum = in_sum;
   assign Busy        = busy_q;
   assign Done        = done_q;

   // Route each returned weight to one sum; the most-negative weight has no
   // positive twin, so its magnitude is pinned to the largest sum value
   always_comb begin
      ex_add = '0;
      in_add = '0;
      if (!WeightData[DATA_WIDTH-1])
         ex_add = WeightData;
      else if (WeightData == SUM_MIN)
         in_add = SUM_MAX;
      else
         in_add = -WeightData;
   end

   saturating_adder #(.DATA_WIDTH(DATA_WIDTH)) u_ex_add (
      .a   (ex_sum),
      .b   (ex_add),
      .sum (ex_next)
   );

   saturating_adder #(.DATA_WIDTH(DATA_WIDTH)) u_in_add (
      .a   (in_sum),
      .b   (in_add),
      .sum (in_next)
   );

   // Read data arrives the cycle after the strobe; remember that a read was issued
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset)
         rd_pending <= 1'b0;
      else
         rd_pending <= accept;
   end

   // Sum registers: cleared on an honoured Start, updated only by valid read data
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         ex_sum <= '0;
         in_sum <= '0;
      end else if (start_ok) begin
         ex_sum <= '0;
         in_sum <= '0;
      end else if (rd_pending) begin
         ex_sum <= ex_next;
         in_sum <= in_next;
      end
   end

   // Sequencing FSM with registered Busy/Done
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state     <= ST_IDLE;
         spike_cnt <= '0;
         nid_q     <= '0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (Start) begin
                  nid_q     <= NeuronID;
                  spike_cnt <= SpikeCount;
                  busy_q    <= 1'b1;
                  if (SpikeCount != '0) begin
                     state <= ST_ACCUM;
                  end else begin
                     state  <= ST_DONE;
                     done_q <= 1'b1;
                  end
               end
            end
            ST_ACCUM: begin
               if (accept) begin
                  spike_cnt <= spike_cnt - 1'b1;
                  if (spike_cnt == CNT_W'(1))
                     state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               state  <= ST_DONE;
               done_q <= 1'b1;
            end
            ST_DONE: begin
               state  <= ST_IDLE;
               done_q <= 1'b0;
               busy_q <= 1'b0;
            end
            default: begin
               state  <= ST_IDLE;
               done_q <= 1'b0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_synaptic_weight_accumulator.sv
// Directed bench for synaptic_weight_accumulator with a one-cycle-latency
// weight memory model keyed on the axon part of the address.
module tb_synaptic_weight_accumulator;

   localparam int DW = 48;
   localparam logic signed [DW-1:0] W_ONE  = 48'sh0001_0000_0000;
   localparam logic signed [DW-1:0] W_HALF = 48'sh0000_8000_0000;
   localparam logic signed [DW-1:0] W_QTR  = 48'sh0000_4000_0000;
   localparam logic signed [DW-1:0] W_BIG  = 48'sh4000_0000_0000;
   localparam logic signed [DW-1:0] W_MIN  = 48'sh8000_0000_0000;
   localparam logic signed [DW-1:0] W_MAX  = 48'sh7FFF_FFFF_FFFF;
   localparam logic signed [DW-1:0] W_JUNK = 48'sh0000_1234_5678;

   logic                 clk;
   logic                 rst_n;
   logic                 start;
   logic [9:0]           neuron_id;
   logic [10:0]          spike_count;
   logic                 spike_valid;
   logic [9:0]           spike_axon;
   logic                 spike_ready;
   logic                 rd_en;
   logic [19:0]          rd_addr;
   logic signed [DW-1:0] rd_data;
   logic signed [DW-1:0] ex_sum;
   logic signed [DW-1:0] in_sum;
   logic                 busy;
   logic                 done;

   int checks   = 0;
   int failures = 0;
   int rd_cnt   = 0;

   synaptic_weight_accumulator dut (
      .Clock       (clk),
      .Reset       (rst_n),
      .Start       (start),
      .NeuronID    (neuron_id),
      .SpikeCount  (spike_count),
      .SpikeValid  (spike_valid),
      .SpikeAxonID (spike_axon),
      .SpikeReady  (spike_ready),
      .WeightRdEn  (rd_en),
      .WeightAddr  (rd_addr),
      .WeightData  (rd_data),
      .ExWeightSum (ex_sum),
      .InWeightSum (in_sum),
      .Busy        (busy),
      .Done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic signed [DW-1:0] weight_of(input logic [9:0] axon);
      case (axon)
         10'd1:   return W_ONE;
         10'd2:   return W_HALF;
         10'd3:   return -W_QTR;
         10'd4:   return W_BIG;
         10'd5:   return W_BIG;
         10'd6:   return W_MIN;
         10'd8:   return -W_ONE;
         default: return '0;
      endcase
   endfunction

   // Weight memory: data valid one cycle after the strobe, junk otherwise
   always @(posedge clk) begin
      if (rd_en) begin
         rd_data <= weight_of(rd_addr[19:10]);
         if (rst_n) rd_cnt <= rd_cnt + 1;
      end else begin
         rd_data <= W_JUNK;
      end
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      rst_n       = 1'b0;
      start       = 1'b0;
      neuron_id   = '0;
      spike_count = '0;
      spike_valid = 1'b0;
      spike_axon  = '0;
      rd_data     = '0;
      tick(); tick();
      #1;
      check_val("rst_busy",  64'(busy), 64'd0);
      check_val("rst_done",  64'(done), 64'd0);
      check_val("rst_ready", 64'(spike_ready), 64'd0);
      check_val("rst_rden",  64'(rd_en), 64'd0);
      check_val("rst_ex",    64'(ex_sum), 64'd0);
      check_val("rst_in",    64'(in_sum), 64'd0);
      tick();
      rst_n = 1'b1;

      // Basic three spike accumulation, neuron 5
      tick(); start = 1'b1; neuron_id = 10'd5; spike_count = 11'd3;
      #1 check_val("t1_idle_busy", 64'(busy), 64'd0);
      tick(); start = 1'b0; spike_valid = 1'b1; spike_axon = 10'd1;
      #1 check_val("t1_busy", 64'(busy), 64'd1);
      check_val("t1_ready", 64'(spike_ready), 64'd1);
      check_val("t1_rden", 64'(rd_en), 64'd1);
      check_val("t1_addr1", 64'(rd_addr), 64'h00405);
      tick(); spike_axon = 10'd2;
      #1 check_val("t1_addr2", 64'(rd_addr), 64'h00805);
      tick(); spike_axon = 10'd3;
      #1 check_val("t1_addr3", 64'(rd_addr), 64'h00C05);
      tick(); spike_axon = 10'd4;
      #1 check_val("t1_drain_ready", 64'(spike_ready), 64'd0);
      check_val("t1_drain_rden", 64'(rd_en), 64'd0);
      check_val("t1_drain_done", 64'(done), 64'd0);
      tick(); spike_valid = 1'b0;
      #1 check_val("t1_done", 64'(done), 64'd1);
      check_val("t1_ex", 64'(ex_sum), 64'h0001_8000_0000);
      check_val("t1_in", 64'(in_sum), 64'h0000_4000_0000);
      tick();
      #1 check_val("t1_done_clr", 64'(done), 64'd0);
      check_val("t1_idle", 64'(busy), 64'd0);
      check_val("t1_ex_hold", 64'(ex_sum), 64'h0001_8000_0000);
      check_val("t1_reads", 64'(rd_cnt), 64'd3);

      // Zero spike count goes straight to DONE
      tick(); start = 1'b1; neuron_id = 10'd1; spike_count = 11'd0;
      tick(); start = 1'b0;
      #1 check_val("t2_done", 64'(done), 64'd1);
      check_val("t2_busy", 64'(busy), 64'd1);
      check_val("t2_ex", 64'(ex_sum), 64'd0);
      check_val("t2_in", 64'(in_sum), 64'd0);
      tick();
      #1 check_val("t2_done_clr", 64'(done), 64'd0);
      check_val("t2_idle", 64'(busy), 64'd0);
      check_val("t2_reads", 64'(rd_cnt), 64'd3);

      // Saturation on both sums
      tick(); start = 1'b1; neuron_id = 10'd0; spike_count = 11'd3;
      tick(); start = 1'b0; spike_valid = 1'b1; spike_axon = 10'd4;
      tick(); spike_axon = 10'd5;
      tick(); spike_axon = 10'd6;
      tick(); spike_valid = 1'b0;
      tick();
      #1 check_val("t3_done", 64'(done), 64'd1);
      check_val("t3_ex_sat", 64'(ex_sum), 64'(W_MAX));
      check_val("t3_in_sat", 64'(in_sum), 64'(W_MAX));
      tick();

      // Stalls between two spikes
      tick(); start = 1'b1; neuron_id = 10'd5; spike_count = 11'd2;
      tick(); start = 1'b0; spike_valid = 1'b1; spike_axon = 10'd1;
      #1 check_val("t4_rden1", 64'(rd_en), 64'd1);
      for (int i = 0; i < 3; i++) begin
         tick(); spike_valid = 1'b0;
         #1 check_val("t4_gap_busy", 64'(busy), 64'd1);
         check_val("t4_gap_rden", 64'(rd_en), 64'd0);
         check_val("t4_gap_ready", 64'(spike_ready), 64'd1);
      end
      tick(); spike_valid = 1'b1; spike_axon = 10'd3;
      #1 check_val("t4_addr2", 64'(rd_addr), 64'h00C05);
      tick(); spike_valid = 1'b0;
      tick();
      #1 check_val("t4_done", 64'(done), 64'd1);
      check_val("t4_ex", 64'(ex_sum), 64'(W_ONE));
      check_val("t4_in", 64'(in_sum), 64'(W_QTR));
      check_val("t4_reads", 64'(rd_cnt), 64'd8);
      tick();

      // Reset in the middle of accumulation
      tick(); start = 1'b1; neuron_id = 10'd9; spike_count = 11'd4;
      tick(); start = 1'b0; spike_valid = 1'b1; spike_axon = 10'd1;
      tick(); spike_valid = 1'b0;
      tick();
      #1 check_val("t5_pre_ex", 64'(ex_sum), 64'(W_ONE));
      rst_n = 1'b0; spike_valid = 1'b1; spike_axon = 10'd2;
      #1 check_val("t5_ex", 64'(ex_sum), 64'd0);
      check_val("t5_in", 64'(in_sum), 64'd0);
      check_val("t5_busy", 64'(busy), 64'd0);
      check_val("t5_ready", 64'(spike_ready), 64'd0);
      check_val("t5_rden", 64'(rd_en), 64'd0);
      check_val("t5_addr", 64'(rd_addr), 64'd0);
      check_val("t5_done", 64'(done), 64'd0);
      tick(); tick();
      rst_n = 1'b1; spike_valid = 1'b0;
      tick(); start = 1'b1; neuron_id = 10'd2; spike_count = 11'd1;
      tick(); start = 1'b0; spike_valid = 1'b1; spike_axon = 10'd8;
      #1 check_val("t5_addr_new", 64'(rd_addr), 64'h02002);
      tick(); spike_valid = 1'b0;
      tick();
      #1 check_val("t5_done_new", 64'(done), 64'd1);
      check_val("t5_in_new", 64'(in_sum), 64'(W_ONE));
      check_val("t5_ex_new", 64'(ex_sum), 64'd0);
      tick();

      // Start pulses outside IDLE are ignored
      tick(); start = 1'b1; neuron_id = 10'd3; spike_count = 11'd2;
      tick(); neuron_id = 10'd7; spike_count = 11'd5; spike_valid = 1'b1; spike_axon = 10'd1;
      #1 check_val("t6_addr1", 64'(rd_addr), 64'h00403);
      tick(); start = 1'b0; spike_axon = 10'd2;
      #1 check_val("t6_addr2", 64'(rd_addr), 64'h00803);
      tick(); spike_valid = 1'b0;
      tick();
      #1 check_val("t6_done", 64'(done), 64'd1);
      check_val("t6_ex", 64'(ex_sum), 64'h0001_8000_0000);
      start = 1'b1; neuron_id = 10'd7; spike_count = 11'd0;
      tick(); start = 1'b0;
      #1 check_val("t6_no_restart_done", 64'(done), 64'd0);
      check_val("t6_no_restart_busy", 64'(busy), 64'd0);
      check_val("t6_ex_hold", 64'(ex_sum), 64'h0001_8000_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/synaptic_weight_accumulator.md
SYNAPTIC_WEIGHT_ACCUMULATOR -- requirements
Module: synaptic_weight_accumulator

Interface
REQ-001 SHALL have parameter INTEGER_WIDTH, default 16, integer bits of signed fixed-point data.
REQ-002 SHALL have parameter DATA_WIDTH_FRAC, default 32, fraction bits.
REQ-003 SHALL have parameter DATA_WIDTH, default INTEGER_WIDTH+DATA_WIDTH_FRAC, weight/sum width.
REQ-004 SHALL have parameter AXON_ID_WIDTH, default 10, spike source index width.
REQ-005 SHALL have parameter NEURON_ID_WIDTH, default 10, target neuron index width.
REQ-006 SHALL use one clock and an asynchronous, active-low reset: Clock  in  1  rising-edge clock; Reset  in  1  asynchronous active-low reset.
REQ-007 Start  in  1  begin accumulation for one neuron (honoured in IDLE only).
REQ-008 NeuronID  in  NEURON_ID_WIDTH  target neuron, sampled with Start.
REQ-009 SpikeCount  in  AXON_ID_WIDTH+1  number of spikes to consume, sampled with Start.
REQ-010 SpikeValid  in  1  spike axon index valid.
REQ-011 SpikeAxonID  in  AXON_ID_WIDTH  presynaptic axon index.
REQ-012 SpikeReady  out  1  block accepts spike this cycle.
REQ-013 WeightRdEn  out  1  weight memory read strobe.
REQ-014 WeightAddr  out  AXON_ID_WIDTH+NEURON_ID_WIDTH  {SpikeAxonID, latched NeuronID}.
REQ-015 WeightData  in  DATA_WIDTH signed  read data, valid exactly one cycle after WeightRdEn.
REQ-016 ExWeightSum  out  DATA_WIDTH signed  excitatory sum, fed to gex adder downstream.
REQ-017 InWeightSum  out  DATA_WIDTH signed  inhibitory magnitude sum, fed to gin adder downstream.
REQ-018 Busy  out  1  high outside IDLE.
REQ-019 Done  out  1  one-cycle pulse, sums final.

Function
REQ-020 States SHALL be IDLE, ACCUM, DRAIN, DONE.
REQ-021 IDLE + Start: latch NeuronID/SpikeCount, clear both sums; -> ACCUM if SpikeCount>0, else -> DONE.
REQ-022 ACCUM: SpikeReady=1 while remaining count>0; accept = SpikeValid & SpikeReady; decrement count on accept.
REQ-023 On accept, WeightRdEn=1 and WeightAddr valid combinationally in that same cycle; no read otherwise.
REQ-024 Last accept (count 1->0) -> DRAIN; DRAIN -> DONE after one cycle; DONE -> IDLE after one cycle with Done=1.
REQ-025 Cycle after each read, WeightData SHALL update sums at that clock edge: weight>=0 adds to ExWeightSum; weight<0 adds -weight to InWeightSum.
REQ-026 Additions SHALL saturate at +(2^(DATA_WIDTH-1)-1); sums never negative; negating most-negative weight SHALL saturate to max.
REQ-027 Throughput one spike per cycle; Done SHALL occur 2 cycles after the last accept edge.
REQ-028 Sums SHALL hold their values from DONE until the next honoured Start.
REQ-029 Start outside IDLE SHALL be ignored; SpikeValid outside ACCUM SHALL not be accepted.
REQ-030 SpikeValid low in ACCUM SHALL stall without timeout.

Reset
REQ-031 Reset low SHALL immediately force IDLE, sums 0, count 0, Done/Busy/SpikeReady/WeightRdEn 0, WeightAddr 0.
REQ-032 Reset mid-operation SHALL abandon the neuron; in-flight WeightData SHALL be discarded.
REQ-033 After release, first honoured Start SHALL behave as from power-up.

Structure
REQ-034 Shared package SHALL hold default widths and state encoding constants (IDLE, ACCUM, DRAIN, DONE).
REQ-035 A sub-module saturating_adder (signed DATA_WIDTH, clamps positive overflow) SHALL be instantiated twice.
REQ-036 Sum registers and control SHALL be in this module; no memory inside the block.

Verification
REQ-037 Start, NeuronID=5, SpikeCount=3, axons 1,2,3 back-to-back, weights +1.0,+0.5,-0.25 (fixed-point, 1.0=2^32) -> addresses {1,5},{2,5},{3,5}; ExWeightSum=1.5, InWeightSum=0.25, Done 2 cycles after third accept.
REQ-038 SpikeCount=0 -> Done at cycle 2 after Start, sums 0, no WeightRdEn.
REQ-039 Two weights of +2^46 each (DATA_WIDTH=48) -> ExWeightSum saturates to 2^47-1; weight -2^47 -> InWeightSum=2^47-1.
REQ-040 SpikeValid gaps of 3 cycles between 2 spikes -> correct sums, no extra reads, Busy held.
REQ-041 Reset asserted in ACCUM after 1 of 4 spikes -> all outputs 0 same cycle; next Start with 1 spike weight -1.0 -> InWeightSum=1.0, ExWeightSum=0.
REQ-042 Start pulsed in ACCUM and DONE -> ignored; latched NeuronID unchanged in WeightAddr.
